// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// One op at a time; radix-2 iterative datapath (shift-add multiply,
// restoring shift-subtract divide) on operand magnitudes, with the sign
// correction applied in a single FIXUP cycle.
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   defined   : multiply leaves CALC once the remaining multiplier bits are 0
//   undefined : multiply always runs ITERS iterations
//
// Ports
//   i_clock, i_reset         clock, synchronous active-high reset
//   i_start, i_op            op request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   i_src_a, i_src_b         multiplicand/dividend, multiplier/divisor
//   o_ready                  high in IDLE
//   o_done                   one-cycle pulse when HI/LO take a result
//   i_flush                  abort the in-flight op (CALC only)
//   i_mf_req                 MFHI/MFLO issued this cycle
//   i_mt_hi, i_mt_lo         MTHI/MTLO write requests, data on i_mt_data
//   o_hi, o_lo               architectural HI/LO
//   o_stall                  combinational hold for Execute while busy
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    output logic             o_ready,
    output logic             o_done,
    input  logic             i_flush,
    input  logic             i_mf_req,
    input  logic             i_mt_hi,
    input  logic             i_mt_lo,
    input  logic [WIDTH-1:0] i_mt_data,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_stall
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_is_div;
    logic               r_sign_a;
    logic               r_sign_b;
    // Multiply: r_a = multiplicand (shifts left), r_b = multiplier (shifts right),
    //           r_acc = 2*WIDTH product accumulator.
    // Divide:   r_a[WIDTH-1:0] = dividend shifting into quotient, r_b = divisor,
    //           r_acc[WIDTH-1:0] = partial remainder.
    logic [2*WIDTH-1:0] r_a;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CW-1:0]      r_cnt;
    logic               r_done;

    // Operand magnitudes and sign flags (signed ops only)
    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    assign w_signed = ~i_op[0];
    assign w_sa     = w_signed & i_src_a[WIDTH-1];
    assign w_sb     = w_signed & i_src_b[WIDTH-1];
    assign w_mag_a  = w_sa ? -i_src_a : i_src_a;
    assign w_mag_b  = w_sb ? -i_src_b : i_src_b;

    // One multiply iteration
    logic [2*WIDTH-1:0] w_mul_sum;
    logic [WIDTH-1:0]   w_b_shr;
    logic               w_last;
    logic               w_mul_exit;

    assign w_mul_sum = r_b[0] ? (r_acc + r_a) : r_acc;
    assign w_b_shr   = r_b >> 1;
    assign w_last    = (r_cnt == CW'(ITERS - 1));
`ifdef MULDIV_EARLY_OUT_EN
    assign w_mul_exit = w_last | (w_b_shr == '0);
`else
    assign w_mul_exit = w_last;
`endif

    // One restoring-divide iteration. The partial remainder is always below
    // the divisor, so the subtraction result fits in WIDTH bits.
    logic [WIDTH:0]     w_div_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [WIDTH-1:0]   w_div_rem;

    assign w_div_sh  = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
    assign w_div_sub = w_div_sh[WIDTH-1:0] - r_b;
    assign w_div_rem = w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];

    // Sign correction
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quo  = (r_sign_a ^ r_sign_b) ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];
    assign w_rem  = r_sign_a ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a      <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_mt_hi) r_hi <= i_mt_data;
                    if (i_mt_lo) r_lo <= i_mt_data;
                    if (i_start && !i_flush) begin
                        r_is_div <= i_op[1];
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_a      <= {{WIDTH{1'b0}}, w_mag_a};
                        r_b      <= w_mag_b;
                        r_sign_a <= w_sa;
                        r_sign_b <= w_sb;
                        r_state  <= S_CALC;
                        if (i_op[1] && (i_src_b == '0)) begin
                            // Divide by zero: preload so the divide FIXUP path
                            // yields LO=all ones, HI=raw dividend.
                            r_a      <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                            r_acc    <= {{WIDTH{1'b0}}, i_src_a};
                            r_sign_a <= 1'b0;
                            r_sign_b <= 1'b0;
                            r_state  <= S_FIXUP;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        else if (!i_op[1] && (i_src_b == '0)) begin
                            r_state <= S_FIXUP;
                        end
`endif
                    end
                end
                S_CALC: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_is_div) begin
                            r_acc <= {{WIDTH{1'b0}}, w_div_rem};
                            r_a   <= {r_a[2*WIDTH-2:0], w_div_ge};
                            if (w_last) r_state <= S_FIXUP;
                        end else begin
                            r_acc <= w_mul_sum;
                            r_a   <= r_a << 1;
                            r_b   <= w_b_shr;
                            if (w_mul_exit) r_state <= S_FIXUP;
                        end
                    end
                end
                S_FIXUP: begin
                    // Flush is ignored here: the result is already committed.
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_done  = r_done;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_stall = (i_mf_req | i_mt_hi | i_mt_lo) & (r_state != S_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed corner cases plus randomized ops,
// checked against an arithmetic reference (64-bit products, native / and %).
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        ready;
    logic        done;
    logic        flush;
    logic        mf_req;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] mt_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [1:0]  cur_op;
    logic [31:0] cur_a;
    logic [31:0] cur_b;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32), .ITERS(32)) dut (
        .i_clock  (clk),
        .i_reset  (reset),
        .i_start  (start),
        .i_op     (op),
        .i_src_a  (src_a),
        .i_src_b  (src_b),
        .o_ready  (ready),
        .o_done   (done),
        .i_flush  (flush),
        .i_mf_req (mf_req),
        .i_mt_hi  (mt_hi),
        .i_mt_lo  (mt_lo),
        .i_mt_data(mt_data),
        .o_hi     (hi),
        .o_lo     (lo),
        .o_stall  (stall)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference result {HI, LO}
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: res = 64'(sa * sb);
            2'd1: res = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Reference latency in cycles from the accept edge to done
    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] b);
        int lat;
        lat = 34;
        if (o[1] && b == 0) lat = 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) begin
            logic [31:0] mag;
            mag = (o == 2'd0 && b[31]) ? -b : b;
            if (mag == 0) lat = 2;
            else begin
                for (int i = 0; i < 32; i++) if (mag[i]) lat = i + 3;
            end
        end
`endif
        return lat;
    endfunction

    // Called at a negedge; returns at the negedge of the first cycle after accept
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        chk("ready_before_start", 64'(ready), 64'd1);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        cur_op = o;
        cur_a  = a;
        cur_b  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic wait_done();
        logic [63:0] e;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        e = ref_res(cur_op, cur_a, cur_b);
        chk("latency", 64'(cyc), 64'(ref_lat(cur_op, cur_b)));
        chk("hi", 64'(hi), 64'(e[63:32]));
        chk("lo", 64'(lo), 64'(e[31:0]));
        m_hi = e[63:32];
        m_lo = e[31:0];
        @(negedge clk);
        chk("done_pulse_one_cycle", 64'(done), 64'd0);
        chk("ready_after_done", 64'(ready), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFFFFFF;
            3: v = 32'h80000000;
            4: v = $urandom_range(0, 255);
            5: v = -($urandom_range(1, 255));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic saw;
        reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        flush = 1'b0; mf_req = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        mf_req = 1'b1;
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_stall_idle", 64'(stall), 64'd0);
        mf_req = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_done();
        chk("multu_hi_const", 64'(hi), 64'hFFFFFFFE);
        chk("multu_lo_const", 64'(lo), 64'h00000001);
        issue(2'd0, 32'hFFFFFFFF, 32'h00000001); wait_done();
        issue(2'd2, 32'hFFFFFFF9, 32'd2);        wait_done();
        chk("div_neg_lo_const", 64'(lo), 64'hFFFFFFFD);
        issue(2'd3, 32'd7, 32'd2);               wait_done();

        // Divide by zero with stall probe
        issue(2'd2, 32'd5, 32'd0);
        mf_req = 1'b1;
        #1 chk("dz_stall_c1", 64'(stall), 64'd1);
        @(negedge clk);
        cyc++;
        #1 chk("dz_stall_c2", 64'(stall), 64'd0);
        mf_req = 1'b0;
        wait_done();

        // Flush in CALC at cycle 10
        issue(2'd3, 32'd100, 32'd7);
        saw = 1'b0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (done) saw = 1'b1;
        end
        flush = 1'b1;
        @(negedge clk);
        cyc++;
        flush = 1'b0;
        chk("flush_ready_c11", 64'(ready), 64'd1);
        repeat (3) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        chk("flush_no_done", 64'(saw), 64'd0);
        chk("flush_hi_kept", 64'(hi), 64'(m_hi));
        chk("flush_lo_kept", 64'(lo), 64'(m_lo));

        // start and flush together in IDLE: nothing accepted
        start = 1'b1; flush = 1'b1; op = 2'd3; src_a = 32'd9; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("start_flush_not_accepted", 64'(ready), 64'd1);

        // MT while busy is stalled and dropped; in IDLE it writes
        issue(2'd3, 32'd100, 32'd7);
        mt_hi = 1'b1; mt_data = 32'hDEADBEEF;
        #1 chk("mt_busy_stall", 64'(stall), 64'd1);
        @(negedge clk);
        cyc++;
        mt_hi = 1'b0;
        chk("mt_busy_hi_unchanged", 64'(hi), 64'(m_hi));
        wait_done();
        mt_hi = 1'b1; mt_data = 32'hDEADBEEF;
        #1 chk("mt_idle_no_stall", 64'(stall), 64'd0);
        @(negedge clk);
        mt_hi = 1'b0;
        m_hi = 32'hDEADBEEF;
        chk("mt_idle_hi", 64'(hi), 64'hDEADBEEF);
        mt_lo = 1'b1; mt_data = 32'h12345678;
        @(negedge clk);
        mt_lo = 1'b0;
        m_lo = 32'h12345678;
        chk("mt_idle_lo", 64'(lo), 64'h12345678);
        chk("mt_lo_hi_kept", 64'(hi), 64'(m_hi));

        // Randomized ops
        for (int k = 0; k < 60; k++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick());
            wait_done();
        end

        // Reset mid-op
        issue(2'd0, 32'h12345678, 32'h9ABCDEF0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midop_rst_hi", 64'(hi), 64'd0);
        chk("midop_rst_lo", 64'(lo), 64'd0);
        chk("midop_rst_ready", 64'(ready), 64'd1);
        repeat (40) @(negedge clk);
        chk("midop_rst_no_late_result", 64'({hi, lo}), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
